// File: rtl/oric_mem_pkg.sv
// rtl/oric_mem_pkg.sv - shared types, FSM codes and lane helper for the Oric memory bridges
package oric_mem_pkg;

   localparam int AW_MAX = 24;

   localparam int MASK_BITS_DEF = 2;
   localparam logic [MASK_BITS_DEF-1:0] MASK_VAL_DEF = 2'b11;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;

   typedef struct packed {
      logic [AW_MAX-1:0] addr;
      logic              we;
      logic [7:0]        data;
   } pend_t;

   // Writes touch one byte lane of the 16-bit word; reads fetch both.
   function automatic logic [1:0] lane_sel(input logic a0, input logic we);
      if (we) return a0 ? 2'b10 : 2'b01;
      return 2'b11;
   endfunction

endpackage

// File: rtl/cpu_sdram_bridge_if.sv
// rtl/cpu_sdram_bridge_if.sv - CPU RAM bus plus SDRAM toggle-handshake port bundle
interface cpu_sdram_bridge_if #(
   parameter int AW = 16
);
   logic [AW-1:0] cpu_a;
   logic [7:0]    cpu_d;
   logic [7:0]    cpu_q;
   logic          cpu_cs;
   logic          cpu_oe;
   logic          cpu_we;
   logic          busy;
   logic          sdram_req;
   logic          sdram_ack;
   logic [AW-1:0] sdram_a;
   logic [1:0]    sdram_ds;
   logic          sdram_we;
   logic [15:0]   sdram_d;
   logic [15:0]   sdram_q;

   modport slave (
      input  cpu_a, cpu_d, cpu_cs, cpu_oe, cpu_we, sdram_ack, sdram_q,
      output cpu_q, busy, sdram_req, sdram_a, sdram_ds, sdram_we, sdram_d
   );

   modport master (
      output cpu_a, cpu_d, cpu_cs, cpu_oe, cpu_we, sdram_ack, sdram_q,
      input  cpu_q, busy, sdram_req, sdram_a, sdram_ds, sdram_we, sdram_d
   );
endinterface

// File: rtl/cpu_sdram_bridge_strobe_detect.sv
// rtl/cpu_sdram_bridge_strobe_detect.sv - CPU strobe history and access trigger generation
module strobe_detect #(
   parameter int AW = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cs_eff,
   input  logic          oe,
   input  logic          we,
   input  logic [AW-1:0] a,
   output logic          rd_trig,
   output logic          wr_trig
);
   logic          rd_now;
   logic          wr_now;
   logic          rd_old;
   logic          wr_old;
   logic [AW-1:0] a_old;

   assign rd_now = cs_eff & oe;
   assign wr_now = cs_eff & we;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_old <= 1'b0;
         wr_old <= 1'b0;
         a_old  <= '0;
      end else begin
         rd_old <= rd_now;
         wr_old <= wr_now;
         a_old  <= a;
      end
   end

   // A held read strobe re-triggers whenever the CPU walks to a new address.
   assign rd_trig = rd_now & (~rd_old | (a != a_old));
   assign wr_trig = wr_now & ~wr_old;

endmodule

// File: rtl/cpu_sdram_bridge.sv
// rtl/cpu_sdram_bridge.sv - CPU RAM bus to toggle-handshake SDRAM port bridge
// Optional one-entry read buffer enabled by defining CPU_SDRAM_BRIDGE_RDBUF_EN.
module cpu_sdram_bridge
   import oric_mem_pkg::*;
#(
   parameter int                   AW         = 16,
   parameter bit                   MASK_EN    = 1'b1,
   parameter int                   MASK_BITS  = MASK_BITS_DEF,
   parameter logic [MASK_BITS-1:0] MASK_VAL   = MASK_BITS'(MASK_VAL_DEF),
   parameter int                   PEND_DEPTH = 1
) (
   input logic               clk,
   input logic               reset,
   cpu_sdram_bridge_if.slave bus
);
   logic          mask_hit;
   logic          cs_eff;
   logic          rd_trig;
   logic          wr_trig;
   logic          trig;
   logic          done;
   logic          issue;
   logic          buf_hit;
   logic [0:0]    state;
   logic [0:0]    next_state;
   logic          req_r;
   logic [AW-1:0] a_r;
   logic          we_r;
   logic [1:0]    ds_r;
   logic [15:0]   d_r;
   logic [7:0]    q_r;
   logic          busy_r;
   logic          pend_valid;
   pend_t         pend_q;
   pend_t         trig_e;
   pend_t         issue_e;
   logic [7:0]    rd_byte;

   assign mask_hit = MASK_EN && (bus.cpu_a[AW-1 -: MASK_BITS] == MASK_VAL);
   assign cs_eff   = bus.cpu_cs & ~mask_hit;

   strobe_detect #(.AW(AW)) u_strobe (
      .clk     (clk),
      .reset   (reset),
      .cs_eff  (cs_eff),
      .oe      (bus.cpu_oe),
      .we      (bus.cpu_we),
      .a       (bus.cpu_a),
      .rd_trig (rd_trig),
      .wr_trig (wr_trig)
   );

   assign trig    = rd_trig | wr_trig;
   assign trig_e  = '{addr: AW_MAX'(bus.cpu_a), we: wr_trig, data: bus.cpu_d};
   assign done    = (state == WAIT) && (bus.sdram_ack == req_r);
   assign rd_byte = a_r[0] ? bus.sdram_q[15:8] : bus.sdram_q[7:0];

   // On completion a fresh trigger is newer than the parked one, so it wins.
   always_comb begin
      issue   = 1'b0;
      issue_e = trig_e;
      if (state == IDLE) begin
         issue = trig & ~buf_hit;
      end else if (done) begin
         if (trig) begin
            issue = 1'b1;
         end else if (pend_valid) begin
            issue   = 1'b1;
            issue_e = pend_q;
         end
      end
   end

   always_comb begin
      next_state = state;
      if (issue)     next_state = WAIT;
      else if (done) next_state = IDLE;
   end

`ifdef CPU_SDRAM_BRIDGE_RDBUF_EN
   logic          buf_valid;
   logic [AW-2:0] buf_addr;
   logic [15:0]   buf_word;
   logic          fill;
   logic [AW-2:0] cur_addr;
   logic          cur_valid;
   logic [7:0]    buf_byte;

   assign fill      = done & ~we_r;
   assign buf_hit   = (state == IDLE) & rd_trig & ~wr_trig & buf_valid &
                      (bus.cpu_a[AW-1:1] == buf_addr);
   assign buf_byte  = bus.cpu_a[0] ? buf_word[15:8] : buf_word[7:0];
   // A write issued in the same clk as a read fill must see the new tag.
   assign cur_addr  = fill ? a_r[AW-1:1] : buf_addr;
   assign cur_valid = fill | buf_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_word  <= '0;
      end else begin
         if (fill) begin
            buf_valid <= 1'b1;
            buf_addr  <= a_r[AW-1:1];
            buf_word  <= bus.sdram_q;
         end
         if (issue && issue_e.we && cur_valid && (issue_e.addr[AW-1:1] == cur_addr)) begin
            if (issue_e.addr[0]) buf_word[15:8] <= issue_e.data;
            else                 buf_word[7:0]  <= issue_e.data;
         end
      end
   end
`else
   assign buf_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_r      <= 1'b0;
         a_r        <= '0;
         we_r       <= 1'b0;
         ds_r       <= 2'b00;
         d_r        <= 16'h0000;
         q_r        <= 8'h00;
         busy_r     <= 1'b0;
         pend_q     <= '0;
         pend_valid <= 1'b0;
      end else begin
         state  <= next_state;
         busy_r <= (next_state == WAIT);
         if (done && !we_r) q_r <= rd_byte;
`ifdef CPU_SDRAM_BRIDGE_RDBUF_EN
         if (buf_hit) q_r <= buf_byte;
`endif
         if (issue) begin
            a_r   <= issue_e.addr[AW-1:0];
            we_r  <= issue_e.we;
            d_r   <= {issue_e.data, issue_e.data};
            ds_r  <= lane_sel(issue_e.addr[0], issue_e.we);
            req_r <= ~req_r;
         end
         if (done) begin
            pend_valid <= 1'b0;
         end else if ((state == WAIT) && trig && (PEND_DEPTH != 0)) begin
            pend_q     <= trig_e;
            pend_valid <= 1'b1;
         end
      end
   end

   generate
      if (AW < AW_MAX) begin : g_addr_pad
         logic unused_issue_hi;
         assign unused_issue_hi = ^issue_e.addr[AW_MAX-1:AW];
      end
   endgenerate

   assign bus.cpu_q     = (mask_hit & bus.cpu_cs) ? 8'h00 : q_r;
   assign bus.busy      = busy_r;
   assign bus.sdram_req = req_r;
   assign bus.sdram_a   = a_r;
   assign bus.sdram_ds  = ds_r;
   assign bus.sdram_we  = we_r;
   assign bus.sdram_d   = d_r;

endmodule

// File: doc/cpu_sdram_bridge.md
Name: cpu_sdram_bridge

Overview:
- Parametrised bridge from an 8-bit retro-CPU RAM bus (cs/oe/we strobes, slow phi-rate timing) to one toggle-handshake port of the shared SDRAM controller.
- Runs in the SDRAM clock domain.
- Edge-detects CPU accesses, issues a single request per access and tracks the ack.
- Steers byte lanes, masks a configurable ROM/IO window, and presents stable read data plus a busy flag.

Parameters:
- AW, 16, CPU byte-address width (16..24).
- MASK_EN, 1, enable the blocked address window.
- MASK_BITS, 2, number of top address bits compared for the window.
- MASK_VAL, 2'b11, top-bit pattern of the blocked window; the default blocks 0xC000-0xFFFF when AW=16.
- PEND_DEPTH, 1, depth of the strobe pending queue; legal values 0 or 1.

Ports:
- clk  in  1  SDRAM clock (72 MHz in the Oric build).
- reset  in  1  asynchronous, active-high.
- cpu_a  in  AW  CPU byte address.
- cpu_d  in  8  CPU write data.
- cpu_q  out  8  read data to CPU.
- cpu_cs  in  1  chip select.
- cpu_oe  in  1  read strobe.
- cpu_we  in  1  write strobe.
- busy  out  1  request outstanding.
- sdram_req  out  1  toggle request.
- sdram_ack  in  1  toggle acknowledge.
- sdram_a  out  AW  latched byte address.
- sdram_ds  out  2  byte-lane enables.
- sdram_we  out  1  write cycle.
- sdram_d  out  16  write data.
- sdram_q  in  16  SDRAM read word.

Behaviour:
- Reset values: all outputs 0. Internal req and ack-shadow are both 0. State is IDLE. The pending slot is empty.
- Effective select: cs_eff = cpu_cs & ~(MASK_EN & cpu_a[AW-1 -: MASK_BITS]==MASK_VAL).
- Registered history, updated every clk: rd_old, wr_old, a_old.
- Trigger conditions, evaluated combinationally each clk:
  - rising edge of cs_eff&oe
  - rising edge of cs_eff&we
  - cs_eff&oe with cpu_a != a_old
- Trigger priority: write over read.
- IDLE:
  - On trigger, in the same clk: latch sdram_a=cpu_a, sdram_we=cpu_we, sdram_d={cpu_d,cpu_d}.
  - sdram_ds = we ? (a[0] ? 2'b10 : 2'b01) : 2'b11.
  - Toggle sdram_req, go to WAIT.
  - busy=1 from the next clk.
- WAIT:
  - When sdram_ack==sdram_req: if the access was a read, capture the byte sdram_a[0] ? sdram_q[15:8] : sdram_q[7:0] into cpu_q.
  - Then go to IDLE, or, if the pending slot is full, issue the pending access in that same clk and stay in WAIT.
- Trigger during WAIT:
  - PEND_DEPTH=1: store address/we/data in the pending slot; a newer trigger overwrites an older one (last wins).
  - PEND_DEPTH=0: drop the trigger.
- Masked access: no request. cpu_q is forced to 8'h00 while the current cpu_a is masked and cs is high; it returns to the latched value otherwise.
- busy is combinational-free: registered, high in WAIT.
- Latency: trigger to req toggle is 1 clk. Ack to cpu_q valid is 1 clk.
- Reset asserted mid-WAIT:
  - Returns to IDLE and clears the pending slot.
  - sdram_req and the ack shadow resync to 0.
  - The controller must also be reset by the same reset.
- Simultaneous ack and new trigger: the ack completes first, and the trigger is issued in the same clk as a new request.

Optional Feature:
- Macro: CPU_SDRAM_BRIDGE_RDBUF_EN.
- When defined: a one-entry read buffer holds the word address (a[AW-1:1]) and 16-bit word of the last completed read.
  - A read trigger that hits the buffer with no intervening write loads cpu_q in 1 clk, issues no request, and leaves busy at 0.
  - Any write to the same word updates the buffer lane.
  - Reset invalidates the buffer.
- When undefined: every trigger issues a request.

Decomposition:
- Shared package oric_mem_pkg:
  - state enum {IDLE, WAIT}
  - lane_sel function (a0, we -> ds)
  - pending-entry struct {addr, we, data}
  - MASK defaults
- One natural sub-module, strobe_detect: history registers plus trigger generation, parametrised by AW.

Test Plan:
- Read at 0x1235 with cs/oe rising; controller acks 4 clk later with q=16'hA55A -> one req toggle, ds=2'b11, cpu_q=8'hA5 one clk after the ack, busy high for 4 clk.
- Write 8'h3C to 0x0400 -> ds=2'b01, sdram_d=16'h3C3C, sdram_we=1, exactly one req toggle.
- Read 0xC010 with defaults -> no req toggle, cpu_q=8'h00, busy stays 0.
- With cs&oe held, change the address 0x2000 -> 0x2001 -> 0x2002 while the first request is outstanding (PEND_DEPTH=1) -> second request issues 0x2002 only, for a total of 2 req toggles.
- Assert reset while in WAIT -> next clk: busy=0, sdram_req=0, pending slot empty; a fresh read then issues normally.
- With CPU_SDRAM_BRIDGE_RDBUF_EN: read 0x0100 then 0x0101 -> second read issues no req, and cpu_q gives the high byte one clk after its trigger.
